pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Owns the architectural PC register and the instruction register (IR) for the simplified multicycle 16-bit RISC-V processor.
- Fetches the word at PC from instruction memory through a req/ack handshake, then holds IR stable for decode and execute.
- Commits the next-address value produced by the PC next-address logic when the control unit asserts pc_write.
- Drives pc and ir[10:0] back into that next-address logic.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- ACK_TIMEOUT, 16, maximum cycles spent in FETCH waiting for imem_ack before error. Legal range 2..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  leave IDLE and begin fetching (level, sampled in IDLE only).
- halt  in  1  stop after the current instruction commits (sampled with pc_write).
- next_pc  in  16  next PC from the next-address logic (PC+1 / branch / jump / register).
- pc_write  in  1  control unit commits next_pc (accepted in HOLD only).
- imem_req  out  1  instruction memory read request.
- imem_addr  out  16  instruction memory address, equal to pc.
- imem_ack  in  1  memory returns data this cycle.
- imem_rdata  in  16  instruction word, valid when imem_ack=1.
- pc  out  16  current PC.
- ir  out  16  instruction register.
- ir_valid  out  1  ir holds the instruction at pc.
- fetch_err  out  1  sticky ack-timeout flag.
- retired  out  16  count of committed instructions, wraps.

Behaviour:
- Reset (rst_n=0, asynchronous, dominates everything):
  - pc=RESET_PC, ir=16'h0000, ir_valid=0, imem_req=0, fetch_err=0, retired=0.
  - state=IDLE, timeout counter=0.
  - Reset mid-fetch abandons the request immediately; a late imem_ack is ignored because the FSM is in IDLE.
- States: IDLE, FETCH, HOLD, ERR. Encoding is a 2-bit registered state.
- IDLE: imem_req=0. On start=1, go to FETCH next cycle.
- FETCH:
  - imem_req=1 and imem_addr=pc, decoded from the registered state so they are glitch-free.
  - Timeout counter increments each FETCH cycle.
  - If imem_ack=1: ir<=imem_rdata, ir_valid<=1, counter<=0, go to HOLD.
  - Else if counter==ACK_TIMEOUT-1: fetch_err<=1, go to ERR.
  - Latency: ack in cycle N gives ir and ir_valid visible in cycle N+1.
  - Zero-wait memory (ack in the first FETCH cycle) gives a 1-cycle fetch.
  - pc_write and halt are ignored in FETCH.
- HOLD:
  - imem_req=0; ir and pc stay stable.
  - On pc_write=1: pc<=next_pc, ir_valid<=0, retired<=retired+1 (16-bit wrap, 16'hFFFF becomes 16'h0000).
  - After pc_write: go to IDLE if halt=1, else FETCH.
  - In IDLE after halt, ir keeps its last value with ir_valid=0; start restarts from the committed pc.
- ERR:
  - imem_req=0, fetch_err=1, ir_valid=0, pc frozen. Stays in ERR until reset.
  - start, pc_write and imem_ack are ignored.
- Stray imem_ack outside FETCH is ignored, with no IR update.
- next_pc is taken verbatim with no arithmetic; PC increment and branch/jump selection are upstream.
- pc_write and start asserted together in HOLD: start is ignored and pc_write acts.

Decomposition:
- Shared package/include file holds:
  - state encodings: ST_IDLE=2'b00, ST_FETCH=2'b01, ST_HOLD=2'b10, ST_ERR=2'b11;
  - the RESET_PC default;
  - the 16-bit data-width constant.
- One natural sub-module: fetch_timeout_ctr, an 8-bit counter with clear, enable and terminal-count output compared against ACK_TIMEOUT-1.
- Keep the FSM, PC register, IR and retired counter in the top module.

Test Plan:
- Reset then start=1 with zero-wait memory (ack same cycle as req, rdata=16'h1234):
  - imem_req=1 with imem_addr=16'h0000 one cycle after start;
  - next cycle ir=16'h1234, ir_valid=1, state HOLD.
- In HOLD, pc_write=1 with next_pc=16'h0042:
  - next cycle pc=16'h0042, ir_valid=0, retired=1;
  - imem_addr=16'h0042 with imem_req=1.
- Memory with 3 wait states (ack on the 4th FETCH cycle):
  - imem_req held high for 4 cycles with a stable address;
  - ir loads once and fetch_err stays 0.
- ACK_TIMEOUT=16 and no ack:
  - fetch_err=1 after exactly 16 FETCH cycles, imem_req drops;
  - a later ack or pc_write changes nothing until rst_n pulses low.
- pc_write=1 with halt=1, next_pc=16'h0100:
  - pc=16'h0100, FSM returns to IDLE, imem_req stays 0;
  - start=1 then fetches from 16'h0100.
- rst_n asserted low mid-FETCH with ack arriving the following cycle:
  - all outputs return to reset values asynchronously and ir is not updated;
  - separately, force retired=16'hFFFF then commit once and check retired=16'h0000.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_unit_pkg
// Brief    : Shared constants and FSM state encodings for the fetch unit.
// Revision : 1.0
// ============================================================================
package pc_fetch_unit_pkg;

   localparam int          c_DATA_W   = 16;
   localparam logic [15:0] c_RESET_PC = 16'h0000;

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_FETCH = 2'b01;
   localparam logic [1:0] ST_HOLD  = 2'b10;
   localparam logic [1:0] ST_ERR   = 2'b11;

endpackage
`default_nettype wire

// File: rtl/pc_fetch_unit_fetch_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module   : fetch_timeout_ctr
// Brief    : 8-bit wait counter; tc flags the last allowed cycle (LIMIT-1).
// Revision : 1.0
// ============================================================================
module fetch_timeout_ctr
   import pc_fetch_unit_pkg::*;
#(
   parameter int LIMIT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam logic [7:0] c_TC = 8'(LIMIT - 1);

   logic [7:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= 8'h00;
      end else if (clr) begin
         r_count <= 8'h00;
      end else if (en) begin
         r_count <= r_count + 8'h01;
      end
   end

   assign tc = (r_count == c_TC);

endmodule
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_unit
// Brief    : PC and IR owner; fetches via req/ack, holds IR, commits next_pc.
// Revision : 1.0
// ============================================================================
module pc_fetch_unit
   import pc_fetch_unit_pkg::*;
#(
   parameter logic [15:0] RESET_PC    = c_RESET_PC,
   parameter int          ACK_TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                halt,
   input  logic [c_DATA_W-1:0] next_pc,
   input  logic                pc_write,
   output logic                imem_req,
   output logic [c_DATA_W-1:0] imem_addr,
   input  logic                imem_ack,
   input  logic [c_DATA_W-1:0] imem_rdata,
   output logic [c_DATA_W-1:0] pc,
   output logic [c_DATA_W-1:0] ir,
   output logic                ir_valid,
   output logic                fetch_err,
   output logic [c_DATA_W-1:0] retired
);

   logic [1:0]          r_state;
   logic [c_DATA_W-1:0] r_pc;
   logic [c_DATA_W-1:0] r_ir;
   logic                r_ir_valid;
   logic                r_fetch_err;
   logic [c_DATA_W-1:0] r_retired;

   logic w_in_fetch;
   logic w_tc;

   assign w_in_fetch = (r_state == ST_FETCH);

   // Counter runs only while fetching; any ack or leaving FETCH rearms it.
   fetch_timeout_ctr #(
      .LIMIT (ACK_TIMEOUT)
   ) u_timeout (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (!w_in_fetch || imem_ack),
      .en    (w_in_fetch),
      .tc    (w_tc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_pc        <= RESET_PC;
         r_ir        <= '0;
         r_ir_valid  <= 1'b0;
         r_fetch_err <= 1'b0;
         r_retired   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               if (imem_ack) begin
                  r_ir       <= imem_rdata;
                  r_ir_valid <= 1'b1;
                  r_state    <= ST_HOLD;
               end else if (w_tc) begin
                  r_fetch_err <= 1'b1;
                  r_ir_valid  <= 1'b0;
                  r_state     <= ST_ERR;
               end
            end
            ST_HOLD: begin
               // start is deliberately not looked at here; pc_write decides.
               if (pc_write) begin
                  r_pc       <= next_pc;
                  r_ir_valid <= 1'b0;
                  r_retired  <= r_retired + 16'h0001;
                  r_state    <= halt ? ST_IDLE : ST_FETCH;
               end
            end
            default: begin
               // ST_ERR is terminal until reset.
               r_fetch_err <= 1'b1;
               r_ir_valid  <= 1'b0;
            end
         endcase
      end
   end

   assign imem_req  = w_in_fetch;
   assign imem_addr = r_pc;
   assign pc        = r_pc;
   assign ir        = r_ir;
   assign ir_valid  = r_ir_valid;
   assign fetch_err = r_fetch_err;
   assign retired   = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch_unit
// Brief    : Scenario tasks plus randomized program run against a transaction model.
// Revision : 1.0
// ============================================================================
module tb_pc_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        halt = 1'b0;
   logic [15:0] next_pc = 16'h0000;
   logic        pc_write = 1'b0;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [15:0] imem_rdata = 16'h0000;
   logic [15:0] pc;
   logic [15:0] ir;
   logic        ir_valid;
   logic        fetch_err;
   logic [15:0] retired;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pc_fetch_unit #(
      .RESET_PC    (16'h0000),
      .ACK_TIMEOUT (16)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .halt       (halt),
      .next_pc    (next_pc),
      .pc_write   (pc_write),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .pc         (pc),
      .ir         (ir),
      .ir_valid   (ir_valid),
      .fetch_err  (fetch_err),
      .retired    (retired)
   );

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return 16'(a * 16'h9E37 + 16'h1234);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      start = 0; halt = 0; pc_write = 0; imem_ack = 0;
      rst_n = 0;
      tick();
      @(negedge clk);
      rst_n = 1;
      tick();
   endtask

   task automatic enter_fetch();
      start = 1;
      tick();
      start = 0;
   endtask

   // Serves one fetch with 'waits' idle cycles before the ack; reports what it saw.
   task automatic do_fetch(input int waits, input logic [15:0] data,
                           output int req_cycles, output bit addr_stable);
      logic [15:0] a0;
      a0 = imem_addr;
      req_cycles = 0;
      addr_stable = 1;
      for (int c = 0; c <= waits; c++) begin
         if (imem_req) req_cycles++;
         if (imem_addr !== a0) addr_stable = 0;
         imem_ack   = (c == waits);
         imem_rdata = data;
         tick();
      end
      imem_ack = 0;
   endtask

   task automatic commit(input logic [15:0] npc, input logic h);
      pc_write = 1; next_pc = npc; halt = h;
      tick();
      pc_write = 0; halt = 0;
   endtask

   task automatic test_reset();
      rst_n = 0;
      #2;
      n_checks++;
      if ({imem_req, pc, ir, ir_valid, fetch_err, retired} !== {1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000}) begin
         n_fail++;
         $display("FAIL reset: req=%b pc=%h ir=%h v=%b err=%b ret=%h, expected all zero",
                  imem_req, pc, ir, ir_valid, fetch_err, retired);
      end
      do_reset();
   endtask

   task automatic test_zero_wait_and_commit();
      int rc; bit st;
      do_reset();
      enter_fetch();
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
         n_fail++; $display("FAIL first_req: req=%b addr=%h expected 1/0000", imem_req, imem_addr);
      end
      do_fetch(0, 16'h1234, rc, st);
      n_checks++;
      if (ir !== 16'h1234 || ir_valid !== 1'b1 || imem_req !== 1'b0) begin
         n_fail++; $display("FAIL zero_wait: ir=%h v=%b req=%b expected 1234/1/0", ir, ir_valid, imem_req);
      end
      commit(16'h0042, 0);
      n_checks++;
      if (pc !== 16'h0042 || ir_valid !== 1'b0 || retired !== 16'h0001 || imem_req !== 1'b1 || imem_addr !== 16'h0042) begin
         n_fail++; $display("FAIL commit: pc=%h v=%b ret=%h req=%b addr=%h expected 0042/0/0001/1/0042",
                            pc, ir_valid, retired, imem_req, imem_addr);
      end
   endtask

   task automatic test_wait_states();
      int rc; bit st;
      do_fetch(3, 16'hBEEF, rc, st);
      n_checks++;
      if (rc !== 4 || st !== 1'b1) begin
         n_fail++; $display("FAIL wait3_req: req_cycles=%0d stable=%b expected 4/1", rc, st);
      end
      n_checks++;
      if (ir !== 16'hBEEF || ir_valid !== 1'b1 || fetch_err !== 1'b0 || imem_req !== 1'b0) begin
         n_fail++; $display("FAIL wait3_ir: ir=%h v=%b err=%b req=%b expected BEEF/1/0/0", ir, ir_valid, fetch_err, imem_req);
      end
   endtask

   task automatic test_timeout();
      int n;
      do_reset();
      enter_fetch();
      n = 0;
      while (fetch_err !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      n_checks++;
      if (n !== 16 || imem_req !== 1'b0 || ir_valid !== 1'b0) begin
         n_fail++; $display("FAIL timeout: cycles=%0d req=%b v=%b expected 16/0/0", n, imem_req, ir_valid);
      end
      imem_ack = 1; imem_rdata = 16'hFFFF; pc_write = 1; next_pc = 16'h1111; start = 1;
      repeat (3) tick();
      imem_ack = 0; pc_write = 0; start = 0;
      n_checks++;
      if (pc !== 16'h0000 || ir !== 16'h0000 || fetch_err !== 1'b1 || imem_req !== 1'b0 || retired !== 16'h0000 || ir_valid !== 1'b0) begin
         n_fail++; $display("FAIL err_sticky: pc=%h ir=%h err=%b req=%b ret=%h v=%b expected 0000/0000/1/0/0000/0",
                            pc, ir, fetch_err, imem_req, retired, ir_valid);
      end
      do_reset();
      n_checks++;
      if (fetch_err !== 1'b0 || imem_req !== 1'b0) begin
         n_fail++; $display("FAIL err_clear: err=%b req=%b expected 0/0", fetch_err, imem_req);
      end
   endtask

   task automatic test_halt_restart();
      int rc; bit st;
      do_reset();
      enter_fetch();
      do_fetch(1, 16'h5A5A, rc, st);
      commit(16'h0100, 1);
      n_checks++;
      if (pc !== 16'h0100 || imem_req !== 1'b0 || ir !== 16'h5A5A || ir_valid !== 1'b0) begin
         n_fail++; $display("FAIL halt: pc=%h req=%b ir=%h v=%b expected 0100/0/5A5A/0", pc, imem_req, ir, ir_valid);
      end
      repeat (3) tick();
      n_checks++;
      if (imem_req !== 1'b0) begin
         n_fail++; $display("FAIL halt_idle: req=%b expected 0", imem_req);
      end
      enter_fetch();
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 16'h0100) begin
         n_fail++; $display("FAIL restart: req=%b addr=%h expected 1/0100", imem_req, imem_addr);
      end
   endtask

   task automatic test_reset_mid_fetch();
      int rc; bit st;
      do_reset();
      enter_fetch();
      do_fetch(0, 16'h7777, rc, st);
      commit(16'h0033, 0);
      #2;
      rst_n = 0;
      #1;
      n_checks++;
      if ({imem_req, pc, ir, ir_valid, fetch_err, retired} !== {1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000}) begin
         n_fail++; $display("FAIL async_reset: req=%b pc=%h ir=%h v=%b err=%b ret=%h expected all zero",
                            imem_req, pc, ir, ir_valid, fetch_err, retired);
      end
      tick();
      imem_ack = 1; imem_rdata = 16'hDEAD;
      @(negedge clk);
      rst_n = 1;
      tick();
      imem_ack = 0;
      n_checks++;
      if (ir !== 16'h0000 || ir_valid !== 1'b0 || imem_req !== 1'b0) begin
         n_fail++; $display("FAIL late_ack: ir=%h v=%b req=%b expected 0000/0/0", ir, ir_valid, imem_req);
      end
   endtask

   task automatic test_retired_wrap();
      int rc; bit st;
      do_reset();
      enter_fetch();
      do_fetch(0, 16'h0001, rc, st);
      force dut.r_retired = 16'hFFFF;
      #1;
      release dut.r_retired;
      #1;
      commit(16'h0002, 0);
      n_checks++;
      if (retired !== 16'h0000) begin
         n_fail++; $display("FAIL retired_wrap: got %h expected 0000", retired);
      end
   endtask

   task automatic test_random_program();
      logic [15:0] m_pc, m_ret, npc, data;
      bit          m_idle, h, st;
      int          waits, rc;
      do_reset();
      m_pc = 16'h0000; m_ret = 16'h0000; m_idle = 1;
      for (int i = 0; i < 40; i++) begin
         if (m_idle) begin
            imem_ack = 1'($urandom_range(0, 1)); imem_rdata = 16'($urandom);
            tick();
            imem_ack = 0;
            enter_fetch();
         end
         n_checks++;
         if (imem_req !== 1'b1 || imem_addr !== m_pc) begin
            n_fail++; $display("FAIL rnd_req[%0d]: req=%b addr=%h expected 1/%h", i, imem_req, imem_addr, m_pc);
         end
         waits = $urandom_range(0, 4);
         data  = mem_word(m_pc);
         do_fetch(waits, data, rc, st);
         n_checks++;
         if (rc !== waits + 1 || !st || ir !== data || ir_valid !== 1'b1) begin
            n_fail++; $display("FAIL rnd_fetch[%0d]: reqc=%0d st=%b ir=%h v=%b expected %0d/1/%h/1",
                               i, rc, st, ir, ir_valid, waits + 1, data);
         end
         repeat ($urandom_range(0, 2)) begin
            imem_ack = 1'($urandom_range(0, 1)); imem_rdata = 16'($urandom); start = 1'($urandom_range(0, 1));
            tick();
            imem_ack = 0; start = 0;
            n_checks++;
            if (ir !== data || pc !== m_pc || imem_req !== 1'b0 || ir_valid !== 1'b1) begin
               n_fail++; $display("FAIL rnd_hold[%0d]: ir=%h pc=%h req=%b v=%b expected %h/%h/0/1",
                                  i, ir, pc, imem_req, ir_valid, data, m_pc);
            end
         end
         npc = 16'($urandom);
         h   = ($urandom_range(0, 3) == 0);
         start = 1'($urandom_range(0, 1));
         commit(npc, h);
         start = 0;
         m_pc = npc; m_ret = m_ret + 16'h0001; m_idle = h;
         n_checks++;
         if (pc !== m_pc || retired !== m_ret || ir_valid !== 1'b0 || imem_req !== !h) begin
            n_fail++; $display("FAIL rnd_commit[%0d]: pc=%h ret=%h v=%b req=%b expected %h/%h/0/%b",
                               i, pc, retired, ir_valid, imem_req, m_pc, m_ret, !h);
         end
      end
   endtask

   initial begin
      test_reset();
      test_zero_wait_and_commit();
      test_wait_states();
      test_timeout();
      test_halt_restart();
      test_reset_mid_fetch();
      test_retired_wrap();
      test_random_program();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
